// File: rtl/seg_pkg.sv
// Shared types and helpers for the seg_scan_mux display path.
// Provides the blank code, conversion FSM states and clog2.
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // Ceiling log2, never below 1 so counters keep a real bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_mux_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// Ports: clk, rst, i_start, i_data -> o_busy, o_done, o_bcd.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int N_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [DATA_W-1:0]       i_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*N_DIGITS-1:0]   o_bcd
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_bin;
  logic [DATA_W-1:0] w_bin_sh;
  logic [BCD_W-1:0]  r_bcd;
  logic [BCD_W-1:0]  w_adj;
  logic [BCD_W-1:0]  w_bcd_sh;
  logic [CNT_W-1:0]  r_cnt;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_bcd_sh = {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
  assign w_bin_sh = {r_bin[DATA_W-2:0], 1'b0};

  // On the final shift cycle this is the finished BCD value.
  assign o_bcd = w_bcd_sh;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_CONV;
      end
      ST_CONV: begin
        o_busy = 1'b1;
        if (r_cnt == LAST) begin
          o_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_start) begin
        r_bin <= i_data;
        r_bcd <= '0;
        r_cnt <= '0;
      end
    end else begin
      r_bin <= w_bin_sh;
      r_bcd <= w_bcd_sh;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Binary to multiplexed 7-seg digit scanner with double-buffered display.
// Ports: clk, rst, in_valid/in_ready/in_data, conv_done, num, an. Macro: LEAD_ZERO_BLANK_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                conv_done,
  output logic [3:0]          num,
  output logic [N_DIGITS-1:0] an
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int IDX_W = clog2(N_DIGITS);
  localparam int REF_W = clog2(REFRESH_DIV);
  localparam logic [N_DIGITS-1:0] AN_RST =
    {{(N_DIGITS-1){1'b1}}, 1'b0};

  logic                w_busy;
  logic                w_done;
  logic [BCD_W-1:0]    w_bcd;

  logic [BCD_W-1:0]    r_buf;
  logic [REF_W-1:0]    r_ref;
  logic [REF_W-1:0]    w_ref_nxt;
  logic                w_wrap;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [N_DIGITS-1:0] r_an;
  logic [N_DIGITS-1:0] w_an_nxt;
  logic [3:0]          r_num;
  logic [3:0]          w_num_nxt;
  logic [3:0]          w_digit;

  bin2bcd_seq #(
    .DATA_W   (DATA_W),
    .N_DIGITS (N_DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .i_start (in_valid & ~w_busy),
    .i_data  (in_data),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  assign in_ready  = ~w_busy;
  assign conv_done = w_done;

  assign w_wrap    = (r_ref == REF_W'(REFRESH_DIV - 1));
  assign w_ref_nxt = w_wrap ? '0 : r_ref + REF_W'(1);

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_wrap) begin
      if (r_idx == IDX_W'(N_DIGITS - 1)) w_idx_nxt = '0;
      else                               w_idx_nxt = r_idx + IDX_W'(1);
    end
  end

  assign w_an_nxt = ~(N_DIGITS'(1) << w_idx_nxt);
  assign w_digit  = r_buf[4*w_idx_nxt +: 4];

`ifdef LEAD_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] r_mask;
  logic [N_DIGITS-1:0] w_mask_new;

  // A digit blanks only if it and every higher digit are zero.
  always_comb begin
    logic w_seen;
    w_seen     = 1'b0;
    w_mask_new = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      w_seen        = w_seen | (w_bcd[4*i +: 4] != 4'd0);
      w_mask_new[i] = ~w_seen;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         r_mask <= AN_RST;
    else if (w_done) r_mask <= w_mask_new;
  end

  assign w_num_nxt = r_mask[w_idx_nxt] ? BLANK_CODE : w_digit;
`else
  assign w_num_nxt = w_digit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
      r_ref <= '0;
      r_idx <= '0;
      r_an  <= AN_RST;
      r_num <= 4'd0;
    end else begin
      if (w_done) r_buf <= w_bcd;
      r_ref <= w_ref_nxt;
      r_idx <= w_idx_nxt;
      r_an  <= w_an_nxt;
      r_num <= w_num_nxt;
    end
  end

  assign an  = r_an;
  assign num = r_num;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed plus random bench for seg_scan_mux with an arithmetic model.
// Model: decimal digits by division, scan slot from edge count.
module tb_seg_scan_mux;

  localparam int DW  = 8;
  localparam int ND  = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          conv_done;
  logic [3:0]    num;
  logic [ND-1:0] an;

  int total = 0;
  int bad   = 0;

  int m_buf  = 0;
  int m_pend = 0;
  int m_left = 0;
  int m_n    = 0;
  bit m_busy = 0;
  int e_num  = 0;
  int m_dones = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .DATA_W      (DW),
    .N_DIGITS    (ND),
    .REFRESH_DIV (DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .conv_done (conv_done),
    .num       (num),
    .an        (an)
  );

  function automatic int pow10(input int i);
    int r;
    r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  function automatic int shown(input int v, input int i);
    int d;
    d = (v / pow10(i)) % 10;
`ifdef LEAD_ZERO_BLANK_EN
    if (i > 0 && v < pow10(i)) d = 15;
`endif
    return d;
  endfunction

  task automatic step();
    int idx;
    logic [ND-1:0] e_an;
    bit e_rdy;
    bit e_done;
    @(posedge clk);
    if (rst) begin
      m_buf  = 0;
      m_busy = 0;
      m_n    = 0;
      e_num  = 0;
    end else begin
      m_n++;
      e_num = shown(m_buf, (m_n / DIV) % ND);
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_buf  = m_pend;
          m_busy = 0;
        end
      end else if (in_valid) begin
        m_busy = 1;
        m_left = DW;
        m_pend = int'(in_data);
      end
    end
    idx    = (m_n / DIV) % ND;
    e_an   = ~(ND'(1) << idx);
    e_rdy  = !m_busy;
    e_done = m_busy && (m_left == 1);
    #1;
    if (conv_done) m_dones++;
    total++;
    assert (in_ready === e_rdy) else begin
      bad++;
      $error("FAIL in_ready got=%0b exp=%0b n=%0d", in_ready, e_rdy, m_n);
    end
    total++;
    assert (conv_done === e_done) else begin
      bad++;
      $error("FAIL conv_done got=%0b exp=%0b n=%0d", conv_done, e_done, m_n);
    end
    total++;
    assert (an === e_an) else begin
      bad++;
      $error("FAIL an got=%b exp=%b n=%0d", an, e_an, m_n);
    end
    total++;
    assert (num === 4'(e_num)) else begin
      bad++;
      $error("FAIL num got=%h exp=%h n=%0d", num, 4'(e_num), m_n);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = DW'(v);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int d0;
    // reset for two cycles
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(3);

    // 173, with a 9 offered during conversion
    d0 = m_dones;
    send(173);
    run(2);
    in_valid = 1'b1;
    in_data  = 8'd9;
    run(4);
    in_valid = 1'b0;
    run(2);
    run(20);
    total++;
    assert (m_dones - d0 == 1) else begin
      bad++;
      $error("FAIL done_count got=%0d exp=1", m_dones - d0);
    end
    total++;
    assert (m_buf == 173) else begin
      bad++;
      $error("FAIL model_buf got=%0d exp=173", m_buf);
    end

    // 255 aborted by reset on the 4th conversion cycle
    send(255);
    run(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(18);

    // small values and zero
    send(5);
    run(DW + 18);
    send(0);
    run(DW + 18);

    // back-to-back with valid held high
    in_valid = 1'b1;
    in_data  = 8'd99;
    run(DW + 2);
    in_data  = 8'd200;
    run(DW + 4);
    in_valid = 1'b0;
    run(18);

    // random traffic, including mid-slot updates
    for (int t = 0; t < 40; t++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom);
      run($urandom_range(1, 6));
      in_valid = 1'b0;
      run($urandom_range(0, 12));
    end

    // boundary values
    send(255);
    run(DW + 18);
    send(10);
    run(DW + 18);
    send(100);
    run(DW + 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
